moving_average_ctrl: RTL and testbench
======================================

Name: moving_average_ctrl

Overview:
Sequencing controller for the moving_average datapath. It accepts window-size reconfiguration requests over a valid/ready handshake and rejects illegal sizes. It flushes the datapath through its active-low reset, waits for the shift register and pipeline to refill, then asserts a qualifier marking output_data as a true average. It sits between the register/config interface and one moving_average instance.

Parameters:
SIZE_MOVING_AVERAGE_WINDOW, 8, width of the window value and of ma_window_set.
SIZE_MOVING_AVERAGE_MAX_WINDOW, 64, largest legal window; must be a power of two.
PIPE_LATENCY, 5, clocks from datapath input to a settled output_data.
FLUSH_CYCLES, 2, clocks that ma_reset_n is held low per reconfiguration; minimum 1.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cfg_window  in  SIZE_MOVING_AVERAGE_WINDOW  requested window; 0 = stop command
cfg_valid  in  1  request valid
cfg_ready  out  1  controller can accept a request
cfg_error  out  1  one-cycle pulse: request rejected
ma_reset_n  out  1  drives the datapath reset (active-low)
ma_window_set  out  SIZE_MOVING_AVERAGE_WINDOW  drives the datapath window_set
ma_enable  out  1  drives the datapath enable
ma_data_valid  out  1  datapath output_data is a valid average
busy  out  1  high in FLUSH or FILL

Behaviour:
- One clock, clk. Reset is synchronous and active-high. All outputs are registered.
- Reset values: state IDLE, cfg_ready=1, cfg_error=0, ma_reset_n=0, ma_window_set=1, ma_enable=0, ma_data_valid=0, busy=0. A reset asserted mid-operation forces these values on the next edge and drops any in-flight request.
- A request is accepted on a clock edge where cfg_valid && cfg_ready.
- Legal windows: 0, or a power of two from 1 to SIZE_MOVING_AVERAGE_MAX_WINDOW.
- An accepted illegal window sets cfg_error=1 for exactly one cycle. State, ma_window_set and all other outputs are unchanged.
- Accepting window 0 moves to IDLE on the next cycle from any state: ma_reset_n=0, ma_enable=0, ma_data_valid=0. ma_window_set keeps its last value.
- Accepting a legal window W>0 latches W into ma_window_set on the next cycle and enters FLUSH.
- States:
  - IDLE: ma_reset_n=0, ma_enable=0, cfg_ready=1.
  - FLUSH: ma_reset_n=0, ma_enable=0, cfg_ready=0. Down-counter loaded with FLUSH_CYCLES-1; at 0, go to FILL.
  - FILL: ma_reset_n=1, ma_enable=1, ma_data_valid=0. Counter loaded with W+PIPE_LATENCY-1; at 0, go to RUN. The counter is 8 bits wide, sufficient for 64+5.
  - RUN: ma_reset_n=1, ma_enable=1, ma_data_valid=1, cfg_ready=1. A new legal W>0 goes to FLUSH; ma_data_valid falls on the next cycle.
- Timing (accept edge = cycle 0): FLUSH occupies cycles 1..FLUSH_CYCLES; FILL occupies the next W+PIPE_LATENCY cycles; ma_data_valid first high at cycle FLUSH_CYCLES+W+PIPE_LATENCY+1.
- cfg_ready in FILL depends on the optional feature below.
- cfg_ready is never high in FLUSH, so no acceptance occurs there.
- If cfg_valid is held while cfg_ready is low, the request waits; no error is raised.

Optional Feature:
MOVING_AVERAGE_CTRL_CFG_LOCK_EN
- Defined: cfg_ready=0 throughout FILL. Requests stall until RUN, so every fill completes.
- Not defined: cfg_ready=1 in FILL. A legal W>0 accepted in FILL restarts FLUSH with the new W. Window 0 goes to IDLE. An illegal window pulses cfg_error and the fill continues uninterrupted.

Test Plan:
- Reset, then cfg_window=8 accepted at cycle 0 -> ma_reset_n low in cycles 1-2; ma_window_set=8 from cycle 1; ma_data_valid rises at cycle 16; busy high in cycles 1-15.
- In RUN, cfg_window=6, then separately cfg_window=128 -> cfg_error high for one cycle each; ma_window_set stays 8; ma_data_valid stays 1.
- In RUN with W=8, cfg_window=0 -> next cycle IDLE: ma_reset_n=0, ma_enable=0, ma_data_valid=0, busy=0, cfg_ready=1.
- cfg_window=64 accepted, then cfg_window=4 offered at the 3rd FILL cycle:
  - Macro undefined -> 4 accepted immediately; ma_data_valid rises 12 cycles after that accept.
  - Macro defined -> cfg_ready stays 0 until RUN (cycle 72); 4 is accepted at cycle 72; ma_data_valid rises at cycle 84.
- cfg_window=1 accepted at cycle 0 -> ma_data_valid at cycle 9. Then reset pulsed for one cycle mid-RUN -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/moving_average_ctrl.sv
`default_nettype none
// ============================================================================
// moving_average_ctrl : window reconfiguration, flush and refill sequencer
//                       for one moving_average datapath instance.
// Optional feature    : MOVING_AVERAGE_CTRL_CFG_LOCK_EN (stall requests in FILL)
// Revision            : 1.0
// ============================================================================
module moving_average_ctrl #(
    parameter int SIZE_MOVING_AVERAGE_WINDOW     = 8,
    parameter int SIZE_MOVING_AVERAGE_MAX_WINDOW = 64,
    parameter int PIPE_LATENCY                   = 5,
    parameter int FLUSH_CYCLES                   = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [SIZE_MOVING_AVERAGE_WINDOW-1:0] cfg_window,
    input  logic                                  cfg_valid,
    output logic                                  cfg_ready,
    output logic                                  cfg_error,
    output logic                                  ma_reset_n,
    output logic [SIZE_MOVING_AVERAGE_WINDOW-1:0] ma_window_set,
    output logic                                  ma_enable,
    output logic                                  ma_data_valid,
    output logic                                  busy
);
    localparam int            WW         = SIZE_MOVING_AVERAGE_WINDOW;
    localparam int            CW         = 8;
    localparam logic [WW-1:0] WIN_ONE    = WW'(1);
    localparam logic [WW-1:0] WIN_MAX    = WW'(SIZE_MOVING_AVERAGE_MAX_WINDOW);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] PIPE_LOAD  = CW'(PIPE_LATENCY - 1);
`ifdef MOVING_AVERAGE_CTRL_CFG_LOCK_EN
    localparam logic          FILL_READY = 1'b0;
`else
    localparam logic          FILL_READY = 1'b1;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_FILL  = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          win_zero;
    logic          win_legal;

    assign accept    = cfg_valid && cfg_ready;
    assign win_zero  = (cfg_window == '0);
    // Power of two (single bit set) no larger than the maximum window.
    assign win_legal = ((cfg_window & (cfg_window - WIN_ONE)) == '0) &&
                       (cfg_window <= WIN_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            cfg_ready     <= 1'b1;
            cfg_error     <= 1'b0;
            ma_reset_n    <= 1'b0;
            ma_window_set <= WIN_ONE;
            ma_enable     <= 1'b0;
            ma_data_valid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            cfg_error <= 1'b0;
            if (accept && win_zero) begin
                state         <= S_IDLE;
                cfg_ready     <= 1'b1;
                ma_reset_n    <= 1'b0;
                ma_enable     <= 1'b0;
                ma_data_valid <= 1'b0;
                busy          <= 1'b0;
            end else if (accept && win_legal) begin
                state         <= S_FLUSH;
                cnt           <= FLUSH_LOAD;
                cfg_ready     <= 1'b0;
                ma_reset_n    <= 1'b0;
                ma_window_set <= cfg_window;
                ma_enable     <= 1'b0;
                ma_data_valid <= 1'b0;
                busy          <= 1'b1;
            end else begin
                // A rejected request only pulses the error; sequencing carries on.
                if (accept) begin
                    cfg_error <= 1'b1;
                end
                case (state)
                    S_FLUSH: begin
                        if (cnt == '0) begin
                            state      <= S_FILL;
                            cnt        <= CW'(ma_window_set) + PIPE_LOAD;
                            cfg_ready  <= FILL_READY;
                            ma_reset_n <= 1'b1;
                            ma_enable  <= 1'b1;
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                    S_FILL: begin
                        if (cnt == '0) begin
                            state         <= S_RUN;
                            cfg_ready     <= 1'b1;
                            ma_data_valid <= 1'b1;
                            busy          <= 1'b0;
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_moving_average_ctrl.sv
`default_nettype none
// Bench for moving_average_ctrl: per-cycle comparison against a timing model
// expressed as phases relative to the most recent accepted window.
module tb_moving_average_ctrl;
    localparam int FC   = 2;
    localparam int PL   = 5;
    localparam int MAXW = 64;
`ifdef MOVING_AVERAGE_CTRL_CFG_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif
    localparam logic [13:0] RESET_VEC = {1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_window = 8'd0;
    logic       cfg_ready, cfg_error, ma_reset_n, ma_enable, ma_data_valid, busy;
    logic [7:0] ma_window_set;
    logic [13:0] obs;

    always #5 clk = ~clk;

    moving_average_ctrl #(
        .SIZE_MOVING_AVERAGE_WINDOW    (8),
        .SIZE_MOVING_AVERAGE_MAX_WINDOW(MAXW),
        .PIPE_LATENCY                  (PL),
        .FLUSH_CYCLES                  (FC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_window   (cfg_window),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_error    (cfg_error),
        .ma_reset_n   (ma_reset_n),
        .ma_window_set(ma_window_set),
        .ma_enable    (ma_enable),
        .ma_data_valid(ma_data_valid),
        .busy         (busy)
    );

    assign obs = {cfg_ready, cfg_error, ma_reset_n, ma_window_set, ma_enable, ma_data_valid, busy};

    int cyc = 0;
    int checks = 0;
    int passes = 0;

    // Model: active window W accepted at cycle t0; outputs follow from cyc-t0.
    bit active = 1'b0;
    bit m_err = 1'b0;
    bit last_acc = 1'b0;
    int t0 = 0;
    int win_set = 1;

    function automatic bit legal(input int w);
        return (w == 0) || (w <= MAXW && $countones(w) == 1);
    endfunction

    // 0 idle, 1 flush, 2 fill, 3 run
    function automatic int phase();
        int rel;
        if (!active) return 0;
        rel = cyc - t0;
        if (rel <= FC) return 1;
        if (rel <= FC + win_set + PL) return 2;
        return 3;
    endfunction

    function automatic logic m_ready();
        int p;
        p = phase();
        if (p == 1) return 1'b0;
        if (p == 2) return !LOCK;
        return 1'b1;
    endfunction

    function automatic logic [13:0] exp_vec();
        int p;
        p = phase();
        return {m_ready(), m_err, p >= 2, 8'(win_set), p >= 2, p == 3, (p == 1) || (p == 2)};
    endfunction

    task automatic tick(input logic v, input logic [7:0] w, input logic r);
        bit acc;
        cfg_valid  = v;
        cfg_window = w;
        reset      = r;
        acc = v && m_ready();
        @(posedge clk);
        cyc++;
        m_err = 1'b0;
        last_acc = acc && !r;
        if (r) begin
            active  = 1'b0;
            win_set = 1;
        end else if (acc) begin
            if (w == 8'd0) begin
                active = 1'b0;
            end else if (legal(int'(w))) begin
                active  = 1'b1;
                t0      = cyc - 1;
                win_set = int'(w);
            end else begin
                m_err = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(1'b0, 8'd0, 1'b1);
        tick(1'b0, 8'd0, 1'b1);
        checks++;
        if (obs !== RESET_VEC) $display("FAIL reset_values got=%h exp=%h", obs, RESET_VEC);
        else passes++;
        tick(1'b0, 8'd0, 1'b0);
        checks++;
        if (obs !== exp_vec()) $display("FAIL reset_idle got=%h exp=%h", obs, exp_vec());
        else passes++;
    endtask

    task automatic test_basic_w8();
        int base, first_dv, busy_n;
        first_dv = -1;
        busy_n = 0;
        tick(1'b1, 8'd8, 1'b0);
        base = cyc - 1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) tick(1'b0, 8'd0, 1'b0);
            checks++;
            if (obs !== exp_vec()) $display("FAIL basic_cycle rel=%0d got=%h exp=%h", cyc - base, obs, exp_vec());
            else passes++;
            if (busy === 1'b1) busy_n++;
            if (ma_data_valid === 1'b1 && first_dv < 0) first_dv = cyc - base;
        end
        checks++;
        if (first_dv != 16) $display("FAIL basic_dv_rise got=%0d exp=16", first_dv);
        else passes++;
        checks++;
        if (busy_n != 15) $display("FAIL basic_busy_len got=%0d exp=15", busy_n);
        else passes++;
    endtask

    task automatic test_illegal();
        logic [7:0] bad [2];
        bad[0] = 8'd6;
        bad[1] = 8'd128;
        for (int k = 0; k < 2; k++) begin
            tick(1'b1, bad[k], 1'b0);
            checks++;
            if (cfg_error !== 1'b1 || ma_window_set !== 8'd8 || ma_data_valid !== 1'b1)
                $display("FAIL illegal_pulse win=%0d got=%h exp_err=1 win_set=8 dv=1", bad[k], obs);
            else passes++;
            tick(1'b0, 8'd0, 1'b0);
            checks++;
            if (obs !== exp_vec()) $display("FAIL illegal_after win=%0d got=%h exp=%h", bad[k], obs, exp_vec());
            else passes++;
        end
    endtask

    task automatic test_stop();
        tick(1'b1, 8'd0, 1'b0);
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 8'd8, 1'b0, 1'b0, 1'b0})
            $display("FAIL stop_idle got=%h exp=%h", obs, {1'b1, 1'b0, 1'b0, 8'd8, 3'b000});
        else passes++;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 8'd0, 1'b0);
            checks++;
            if (obs !== exp_vec()) $display("FAIL stop_hold got=%h exp=%h", obs, exp_vec());
            else passes++;
        end
    endtask

    task automatic test_fill_interrupt();
        int base, first_dv, rel;
        bit got, v;
        got = 1'b0;
        first_dv = -1;
        tick(1'b1, 8'd64, 1'b0);
        base = cyc - 1;
        for (int i = 0; i < 120 && first_dv < 0; i++) begin
            rel = cyc - base;
            v = (rel >= 5) && !got;
            tick(v, v ? 8'd4 : 8'd0, 1'b0);
            if (v && last_acc) got = 1'b1;
            checks++;
            if (obs !== exp_vec()) $display("FAIL fill_cycle rel=%0d got=%h exp=%h", cyc - base, obs, exp_vec());
            else passes++;
            if (got && ma_data_valid === 1'b1) first_dv = cyc - base;
        end
        checks++;
        if (first_dv != (LOCK ? 84 : 17))
            $display("FAIL fill_dv_rise got=%0d exp=%0d", first_dv, LOCK ? 84 : 17);
        else passes++;
    endtask

    task automatic test_w1_reset();
        int base, first_dv;
        first_dv = -1;
        tick(1'b1, 8'd1, 1'b0);
        base = cyc - 1;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) tick(1'b0, 8'd0, 1'b0);
            checks++;
            if (obs !== exp_vec()) $display("FAIL w1_cycle rel=%0d got=%h exp=%h", cyc - base, obs, exp_vec());
            else passes++;
            if (ma_data_valid === 1'b1 && first_dv < 0) first_dv = cyc - base;
        end
        checks++;
        if (first_dv != 9) $display("FAIL w1_dv_rise got=%0d exp=9", first_dv);
        else passes++;
        tick(1'b0, 8'd0, 1'b1);
        checks++;
        if (obs !== RESET_VEC) $display("FAIL midrun_reset got=%h exp=%h", obs, RESET_VEC);
        else passes++;
        tick(1'b0, 8'd0, 1'b0);
    endtask

    task automatic test_random();
        int r, sel;
        logic v, rs;
        logic [7:0] w;
        for (int i = 0; i < 600; i++) begin
            r   = int'($urandom_range(0, 99));
            sel = int'($urandom_range(0, 9));
            v   = (r < 12);
            rs  = (r == 99);
            if (sel < 7)       w = 8'(1 << $urandom_range(0, 3));
            else if (sel == 7) w = 8'd0;
            else               w = 8'($urandom_range(0, 255));
            tick(v, w, rs);
            checks++;
            if (obs !== exp_vec()) $display("FAIL random_cycle cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            else passes++;
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_w8();
        test_illegal();
        test_stop();
        test_fill_interrupt();
        test_w1_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
`default_nettype wire
